// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared width default and FSM state encoding for the 2-point IFFT butterfly
package fft_pkg;

  localparam int W_DEF = 16;

  typedef enum logic [1:0] {
    S_IN0  = 2'd0,
    S_IN1  = 2'd1,
    S_OUT0 = 2'd2,
    S_OUT1 = 2'd3
  } state_t;

endpackage

// File: rtl/butterfly2_ifft_if.sv
// rtl/butterfly2_ifft_if.sv - sample stream interface of the 2-point IFFT butterfly
// Signals: in_valid/in_ready/in_re/in_im (frequency-domain input),
//          out_valid/out_ready/out_re/out_im/out_idx (time-domain output), busy.
// Modports: master = sample source/sink side, slave = butterfly side.
interface butterfly2_ifft_if
  import fft_pkg::*;
#(
  parameter int W = W_DEF
);

  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_re;
  logic signed [W-1:0] in_im;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;
  logic                out_idx;
  logic                busy;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, busy
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, busy
  );

endinterface

// File: rtl/butterfly2_ifft_core.sv
// rtl/butterfly2_ifft_core.sv - one component of the butterfly: (a +/- b) / 2, saturated
// Ports: a, b (W-bit signed operands), y (W-bit signed result).
// Parameter SUB selects difference (1) or sum (0).
// Macro BUTTERFLY2_IFFT_ROUND_EN adds round-half-up before the halving shift.
module butterfly2_ifft_core
  import fft_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter bit SUB = 1'b0
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  localparam logic signed [W+1:0] SAT_MAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] SAT_MIN = {3'b111, {(W-1){1'b0}}};

  logic signed [W+1:0] a_ext;
  logic signed [W+1:0] b_ext;
  logic signed [W+1:0] acc;
  logic signed [W+1:0] shifted;

  assign a_ext = {{2{a[W-1]}}, a};
  assign b_ext = {{2{b[W-1]}}, b};

  always_comb begin
    acc     = SUB ? (a_ext - b_ext) : (a_ext + b_ext);
`ifdef BUTTERFLY2_IFFT_ROUND_EN
    acc     = acc + {{(W+1){1'b0}}, 1'b1};
`endif
    // Arithmetic shift floors toward minus infinity.
    shifted = acc >>> 1;
    y       = shifted[W-1:0];
    // Only reachable with rounding (e.g. max - min + 1), kept in both builds.
    if (shifted > SAT_MAX) begin
      y = SAT_MAX[W-1:0];
    end else if (shifted < SAT_MIN) begin
      y = SAT_MIN[W-1:0];
    end
  end

endmodule

// File: rtl/butterfly2_ifft.sv
// rtl/butterfly2_ifft.sv - streaming 2-point inverse butterfly, x0=(X0+X1)/2, x1=(X0-X1)/2
// Ports: clk, rst (sync active-high), bus (butterfly2_ifft_if.slave).
// Optional macro: BUTTERFLY2_IFFT_ROUND_EN (round half up before halving).
module butterfly2_ifft
  import fft_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  butterfly2_ifft_if.slave       bus
);

  state_t state;
  state_t state_nxt;

  logic in_rdy;
  logic out_vld;
  logic in_fire;

  logic signed [W-1:0] x0_re_q;
  logic signed [W-1:0] x0_im_q;
  logic signed [W-1:0] y0_re_q;
  logic signed [W-1:0] y0_im_q;
  logic signed [W-1:0] y1_re_q;
  logic signed [W-1:0] y1_im_q;

  logic signed [W-1:0] y0_re_d;
  logic signed [W-1:0] y0_im_d;
  logic signed [W-1:0] y1_re_d;
  logic signed [W-1:0] y1_im_d;

  always_comb begin
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    state_nxt = state;
    case (state)
      S_IN0: begin
        in_rdy = 1'b1;
        if (bus.in_valid) state_nxt = S_IN1;
      end
      S_IN1: begin
        in_rdy = 1'b1;
        if (bus.in_valid) state_nxt = S_OUT0;
      end
      S_OUT0: begin
        out_vld = 1'b1;
        if (bus.out_ready) state_nxt = S_OUT1;
      end
      S_OUT1: begin
        out_vld = 1'b1;
        if (bus.out_ready) state_nxt = S_IN0;
      end
      default: state_nxt = S_IN0;
    endcase
  end

  assign in_fire = in_rdy & bus.in_valid;

  // X1 is never stored: results are computed from the held X0 and live X1.
  butterfly2_ifft_core #(.W(W), .SUB(1'b0)) u_sum_re (.a(x0_re_q), .b(bus.in_re), .y(y0_re_d));
  butterfly2_ifft_core #(.W(W), .SUB(1'b0)) u_sum_im (.a(x0_im_q), .b(bus.in_im), .y(y0_im_d));
  butterfly2_ifft_core #(.W(W), .SUB(1'b1)) u_dif_re (.a(x0_re_q), .b(bus.in_re), .y(y1_re_d));
  butterfly2_ifft_core #(.W(W), .SUB(1'b1)) u_dif_im (.a(x0_im_q), .b(bus.in_im), .y(y1_im_d));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IN0;
      x0_re_q <= '0;
      x0_im_q <= '0;
      y0_re_q <= '0;
      y0_im_q <= '0;
      y1_re_q <= '0;
      y1_im_q <= '0;
    end else begin
      state <= state_nxt;
      if (in_fire && state == S_IN0) begin
        x0_re_q <= bus.in_re;
        x0_im_q <= bus.in_im;
      end
      if (in_fire && state == S_IN1) begin
        y0_re_q <= y0_re_d;
        y0_im_q <= y0_im_d;
        y1_re_q <= y1_re_d;
        y1_im_q <= y1_im_d;
      end
    end
  end

  // Outputs come straight from registers and state, so they hold under backpressure.
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.busy      = (state != S_IN0);
  assign bus.out_idx   = (state == S_OUT1);
  assign bus.out_re    = (state == S_OUT1) ? y1_re_q : y0_re_q;
  assign bus.out_im    = (state == S_OUT1) ? y1_im_q : y0_im_q;

endmodule

// File: tb/tb_butterfly2_ifft.sv
// tb/tb_butterfly2_ifft.sv - self-checking bench for butterfly2_ifft
module tb_butterfly2_ifft;

  localparam int W      = 16;
  localparam int NPAIRS = 40;
  localparam int SMAX   = 32767;
  localparam int SMIN   = -32768;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  int exp_re[$];
  int exp_im[$];
  int exp_idx[$];

  butterfly2_ifft_if #(.W(W)) bif ();

  butterfly2_ifft #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: exact (a +/- b [+1]) / 2 floored toward minus infinity, then clamped.
  function automatic int ref_half(input int a, input int b, input bit sub);
    int s;
    int r;
    s = sub ? (a - b) : (a + b);
`ifdef BUTTERFLY2_IFFT_ROUND_EN
    s = s + 1;
`endif
    if (s >= 0) r = s / 2;
    else        r = -((1 - s) / 2);
    if (r > SMAX) r = SMAX;
    if (r < SMIN) r = SMIN;
    return r;
  endfunction

  function automatic int rnd_sample();
    int k;
    k = int'($urandom_range(0, 7));
    if (k == 0) return SMAX;
    if (k == 1) return SMIN;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic put(input int re, input int im);
    int n;
    n = 0;
    @(negedge clk);
    bif.in_valid = 1'b1;
    bif.in_re    = W'(re);
    bif.in_im    = W'(im);
    while (!bif.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("put_ready", int'(bif.in_ready), 1);
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
  endtask

  task automatic get(output int re, output int im, output int idx);
    int n;
    n = 0;
    @(negedge clk);
    bif.out_ready = 1'b1;
    while (!bif.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("get_valid", int'(bif.out_valid), 1);
    re  = int'(bif.out_re);
    im  = int'(bif.out_im);
    idx = int'(bif.out_idx);
    @(posedge clk);
    #1;
    bif.out_ready = 1'b0;
  endtask

  task automatic get_expect(input string tag, input int ere, input int eim, input int eidx);
    int re, im, idx;
    get(re, im, idx);
    check({tag, "_re"}, re, ere);
    check({tag, "_im"}, im, eim);
    check({tag, "_idx"}, idx, eidx);
  endtask

  task automatic producer();
    int sent, phase, r, i, a_re, a_im, cyc;
    sent = 0; phase = 0; a_re = 0; a_im = 0; cyc = 0;
    while (sent < NPAIRS && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      bif.in_valid = ($urandom_range(0, 3) != 0);
      r = rnd_sample();
      i = rnd_sample();
      bif.in_re = W'(r);
      bif.in_im = W'(i);
      if (bif.in_valid && bif.in_ready) begin
        if (phase == 0) begin
          a_re  = r;
          a_im  = i;
          phase = 1;
        end else begin
          exp_re.push_back(ref_half(a_re, r, 1'b0));
          exp_im.push_back(ref_half(a_im, i, 1'b0));
          exp_idx.push_back(0);
          exp_re.push_back(ref_half(a_re, r, 1'b1));
          exp_im.push_back(ref_half(a_im, i, 1'b1));
          exp_idx.push_back(1);
          phase = 0;
          sent++;
        end
      end
    end
    @(negedge clk);
    bif.in_valid = 1'b0;
    check("rnd_sent", sent, NPAIRS);
  endtask

  task automatic consumer();
    int got, cyc;
    got = 0; cyc = 0;
    while (got < 2 * NPAIRS && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      bif.out_ready = ($urandom_range(0, 1) != 0);
      if (bif.out_valid && bif.out_ready) begin
        check("rnd_q_nonempty", int'(exp_re.size() > 0), 1);
        if (exp_re.size() > 0) begin
          check("rnd_re", int'(bif.out_re), exp_re.pop_front());
          check("rnd_im", int'(bif.out_im), exp_im.pop_front());
          check("rnd_idx", int'(bif.out_idx), exp_idx.pop_front());
        end
        got++;
      end
    end
    @(negedge clk);
    bif.out_ready = 1'b0;
    check("rnd_count", got, 2 * NPAIRS);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bif.in_valid  = 1'b0;
    bif.in_re     = '0;
    bif.in_im     = '0;
    bif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(bif.in_ready), 1);
    check("rst_out_valid", int'(bif.out_valid), 0);
    check("rst_busy", int'(bif.busy), 0);
    check("rst_out_re", int'(bif.out_re), 0);
    check("rst_out_im", int'(bif.out_im), 0);
    check("rst_out_idx", int'(bif.out_idx), 0);
    rst = 1'b0;

    // Basic pair and one-cycle latency.
    put(100, 20);
    check("b_busy_after_x0", int'(bif.busy), 1);
    check("b_no_valid_after_x0", int'(bif.out_valid), 0);
    put(40, -10);
    check("b_latency_valid", int'(bif.out_valid), 1);
    check("b_in_ready_low", int'(bif.in_ready), 0);
    get_expect("b_x0", 70, 5, 0);
    get_expect("b_x1", 30, 15, 1);

    // Rounding corner.
    put(3, -3);
    put(0, 0);
`ifdef BUTTERFLY2_IFFT_ROUND_EN
    get_expect("rnd_corner_x0", 2, -1, 0);
    get_expect("rnd_corner_x1", 2, -1, 1);
`else
    get_expect("trn_corner_x0", 1, -2, 0);
    get_expect("trn_corner_x1", 1, -2, 1);
`endif

    // Extremes: difference of max and min, sum of two minimums.
    put(SMAX, SMIN);
    put(SMIN, SMIN);
    get_expect("ext_x0", ref_half(SMAX, SMIN, 1'b0), -32768, 0);
    get_expect("ext_x1", 32767, ref_half(SMIN, SMIN, 1'b1), 1);

    // Backpressure in S_OUT0 with junk input offered.
    put(50, 10);
    put(20, -4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bif.in_valid = 1'b1;
      bif.in_re    = W'(999);
      bif.in_im    = W'(-999);
      check("bp_valid", int'(bif.out_valid), 1);
      check("bp_in_ready", int'(bif.in_ready), 0);
      check("bp_re", int'(bif.out_re), 35);
      check("bp_im", int'(bif.out_im), 3);
      check("bp_idx", int'(bif.out_idx), 0);
    end
    bif.in_valid = 1'b0;
    get_expect("bp_x0", 35, 3, 0);
    get_expect("bp_x1", 15, 7, 1);
    check("bp_back_idle", int'(bif.busy), 0);

    // Reset in S_IN1 while X1 is being offered: reset wins, X0 discarded.
    put(77, 5);
    @(negedge clk);
    bif.in_valid = 1'b1;
    bif.in_re    = W'(1234);
    bif.in_im    = W'(-1234);
    rst          = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bif.in_valid = 1'b0;
    check("rs_in_ready", int'(bif.in_ready), 1);
    check("rs_busy", int'(bif.busy), 0);
    check("rs_out_valid", int'(bif.out_valid), 0);
    put(10, 0);
    put(2, 0);
    get_expect("rs_x0", 6, 0, 0);
    get_expect("rs_x1", 4, 0, 1);

    // Random back-to-back traffic with gaps on both sides.
    fork
      producer();
      consumer();
    join
    check("rnd_leftover", int'(exp_re.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/butterfly2_ifft.md
BUTTERFLY2_IFFT -- requirements
Module: butterfly2_ifft

Interface
REQ-001 Parameter W, default 16: sample component width, signed two's complement.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  input sample present.
REQ-006 in_ready  out  1  block accepts input this cycle.
REQ-007 in_re, in_im  in  W  frequency-domain sample, real and imaginary parts.
REQ-008 out_valid  out  1  output sample present.
REQ-009 out_ready  in  1  downstream accepts output.
REQ-010 out_re, out_im  out  W  time-domain sample, real and imaginary parts.
REQ-011 out_idx  out  1  0 = x0, 1 = x1.
REQ-012 busy  out  1  high in any state other than S_IN0.

Function
REQ-013 The block SHALL implement a streaming 2-point inverse butterfly: x0 = (X0+X1)/2, x1 = (X0-X1)/2, applied independently to re and im.
REQ-014 The FSM SHALL have states S_IN0, S_IN1, S_OUT0 and S_OUT1.
- S_IN0 -> S_IN1 on input transfer.
- S_IN1 -> S_OUT0 on input transfer.
- S_OUT0 -> S_OUT1 on output transfer.
- S_OUT1 -> S_IN0 on output transfer.
REQ-015 An input transfer SHALL occur when in_valid & in_ready; an output transfer SHALL occur when out_valid & out_ready.
REQ-016 in_ready SHALL be 1 exactly in S_IN0 and S_IN1; out_valid SHALL be 1 exactly in S_OUT0 and S_OUT1.
REQ-017 X0 SHALL be registered on the S_IN0 transfer.
REQ-018 Both results SHALL be computed from X0 and the live X1 inputs and registered on the S_IN1 transfer.
REQ-019 out_valid SHALL assert the cycle after X1 is accepted, giving a latency of 1 cycle.
REQ-020 Minimum throughput SHALL be one pair per 4 cycles.
REQ-021 out_re, out_im and out_idx SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 out_idx SHALL be 0 in S_OUT0 and 1 in S_OUT1.
REQ-023 Sum and difference SHALL be formed at W+2 bits by sign extension, then arithmetically shifted right by 1 (truncation toward minus infinity).
REQ-024 The shifted result SHALL be saturated to the range [-2^(W-1), 2^(W-1)-1].
REQ-025 In any state, in_valid while in_ready=0 SHALL be ignored without side effects.
REQ-026 In any state, out_ready while out_valid=0 SHALL be ignored without side effects.

Reset
REQ-027 On rst=1 at a clock edge, the state SHALL become S_IN0 and any partial pair or pending output SHALL be discarded.
REQ-028 Reset values SHALL be: in_ready=1, out_valid=0, busy=0, out_re=0, out_im=0, out_idx=0, X0 register=0.
REQ-029 rst SHALL take priority over simultaneous transfers in the same cycle.

Configuration
REQ-030 Macro BUTTERFLY2_IFFT_ROUND_EN: when defined, 1 SHALL be added to the (W+2)-bit sum or difference before the shift (round half up), followed by saturation.
REQ-031 When BUTTERFLY2_IFFT_ROUND_EN is undefined, the block SHALL truncate with no rounding adder present; the saturation logic SHALL be kept in both builds.

Structure
REQ-032 Package fft_pkg SHALL hold the default width W_DEF=16 and the state encoding (S_IN0=2'd0, S_IN1=2'd1, S_OUT0=2'd2, S_OUT1=2'd3).
REQ-033 One combinational sub-module, butterfly2_ifft_core, SHALL compute scale, round and saturate for one component; it is instantiated 4 times (re/im x sum/difference).

Verification
REQ-034 X0=(100,20), X1=(40,-10), out_ready=1 -> x0=(70,5) with idx 0, then x1=(30,15) with idx 1; out_valid rises 1 cycle after X1 is accepted.
REQ-035 X0=(3,-3), X1=(0,0):
- truncate build -> x0=x1=(1,-2).
- ROUND_EN build -> x0=x1=(2,-1).
REQ-036 X0=(32767,-32768), X1=(-32768,-32768):
- truncate build -> x1.re=32767, x0.im=-32768.
- ROUND_EN build -> x1.re saturates to 32767.
REQ-037 Backpressure: out_ready=0 for 5 cycles in S_OUT0 -> outputs stable, in_ready=0, no new input accepted; release -> x0 then x1 in order.
REQ-038 rst pulsed in S_IN1 with X0 held -> next pair (10,0)/(2,0) yields x0=(6,0), x1=(4,0), with no stale data.
REQ-039 Back-to-back random pairs with random in_valid/out_ready gaps -> all results match a reference model and the pair count is conserved.
